vec_mag_sqrt_feeder: RTL and testbench

- Upstream feeder and sequencer for the 32-bit integer square-root stage.
- Accepts a signed 16-bit vector (X, Y) over a valid/ready handshake and computes X²+Y² with a sequential shift-add squarer.
- Launches the square-root stage with a one-cycle start pulse, waits for its ready flag, and returns both the magnitude and the magnitude-squared over a valid/ready handshake.
- Sits between the vector-source pipeline and the square-root stage in the accelerated-calculation datapath.

---
 rtl/vec_mag_pkg.sv | 27 ++
 rtl/vec_mag_sqrt_feeder_if.sv | 28 ++
 rtl/seq_square16.sv | 44 ++++
 rtl/vec_mag_sqrt_feeder.sv | 143 ++++++++++++++
 tb/tb_vec_mag_sqrt_feeder.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/vec_mag_pkg.sv
// Shared types and widths for the vector-magnitude feeder.
// Used by the squarer, the handshake interface and the sequencer.
package vec_mag_pkg;

  localparam int MAG_IN_W   = 16;
  localparam int MAG2_W     = 32;
  localparam int SQRT_OUT_W = 16;
  localparam int SQ_STEPS   = 16;

  typedef enum logic [2:0] {
    IDLE,
    SQX,
    SQY,
    START,
    WAIT,
    DONE
  } state_t;

  // |-32768| = 32768 still fits once viewed as unsigned
  function automatic logic [MAG_IN_W-1:0] abs16(
    input logic signed [MAG_IN_W-1:0] v
  );
    return v[MAG_IN_W-1] ? MAG_IN_W'(~v + 1'b1)
                         : MAG_IN_W'(v);
  endfunction

endpackage

// File: rtl/vec_mag_sqrt_feeder_if.sv
// Vector-in / magnitude-out valid-ready bundle.
// slave = feeder side, master = source/consumer side.
interface vec_mag_sqrt_feeder_if;
  import vec_mag_pkg::*;

  logic                         in_valid;
  logic                         in_ready;
  logic signed [MAG_IN_W-1:0]   in_x;
  logic signed [MAG_IN_W-1:0]   in_y;
  logic                         out_valid;
  logic                         out_ready;
  logic [SQRT_OUT_W-1:0]        out_mag;
  logic [MAG2_W-1:0]            out_mag2;
  logic                         out_err;

  modport slave (
    input  in_valid, in_x, in_y, out_ready,
    output in_ready, out_valid, out_mag,
    output out_mag2, out_err
  );

  modport master (
    output in_valid, in_x, in_y, out_ready,
    input  in_ready, out_valid, out_mag,
    input  out_mag2, out_err
  );

endinterface

// File: rtl/seq_square16.sv
// Sequential shift-add squarer, one partial product per cycle.
// start clears the step count and loads acc_in; step adds op<<cnt.
module seq_square16
  import vec_mag_pkg::*;
(
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                start,
  input  logic                step,
  input  logic [MAG_IN_W-1:0] op,
  input  logic [MAG2_W-1:0]   acc_in,
  output logic [MAG2_W-1:0]   sum,
  output logic                done
);

  localparam int CW = $clog2(SQ_STEPS);

  logic [CW-1:0]     cnt;
  logic [MAG2_W-1:0] acc;
  logic [MAG2_W-1:0] part;

  always_comb begin
    part = '0;
    if (op[cnt])
      part = MAG2_W'(op) << cnt;
    sum  = acc + part;
    done = step && (cnt == CW'(SQ_STEPS - 1));
  end

  // cnt wraps to 0 after the last step, ready for the next operand
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      acc <= '0;
      cnt <= '0;
    end else if (start) begin
      acc <= acc_in;
      cnt <= '0;
    end else if (step) begin
      acc <= sum;
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/vec_mag_sqrt_feeder.sv
// Squares and sums a signed vector, launches the sqrt stage,
// then returns magnitude and magnitude-squared.
module vec_mag_sqrt_feeder
  import vec_mag_pkg::*;
#(
  parameter int W            = 16,
  parameter int SQRT_TIMEOUT = 64
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  vec_mag_sqrt_feeder_if.slave  io,
  output logic [MAG2_W-1:0]     sqrt_x,
  output logic                  sqrt_start,
  input  logic                  sqrt_rdy,
  input  logic [SQRT_OUT_W-1:0] sqrt_y
);

  localparam int TW = $clog2(SQRT_TIMEOUT);

  state_t state;
  state_t nstate;

  logic [W-1:0]          ax;
  logic [W-1:0]          ay;
  logic [W-1:0]          sq_op;
  logic                  sq_start;
  logic                  sq_step;
  logic                  sq_done;
  logic [MAG2_W-1:0]     sq_sum;
  logic [TW-1:0]         tcnt;
  logic                  tmo;
  logic                  out_valid;
  logic                  out_err;
  logic [SQRT_OUT_W-1:0] out_mag;
  logic [MAG2_W-1:0]     out_mag2;

  assign tmo = (tcnt == TW'(SQRT_TIMEOUT - 1));

  assign io.in_ready  = (state == IDLE);
  assign io.out_valid = out_valid;
  assign io.out_mag   = out_mag;
  assign io.out_mag2  = out_mag2;
  assign io.out_err   = out_err;

  seq_square16 u_sq (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .start  (sq_start),
    .step   (sq_step),
    .op     (sq_op),
    .acc_in (MAG2_W'(0)),
    .sum    (sq_sum),
    .done   (sq_done)
  );

  always_comb begin
    nstate   = state;
    sq_start = 1'b0;
    sq_step  = 1'b0;
    sq_op    = ax;
    unique case (state)
      IDLE: begin
        sq_start = io.in_valid;
        if (io.in_valid)
          nstate = SQX;
      end
      SQX: begin
        sq_step = 1'b1;
        if (sq_done)
          nstate = SQY;
      end
      SQY: begin
        sq_step = 1'b1;
        sq_op   = ay;
        if (sq_done)
          nstate = START;
      end
      START:
        nstate = WAIT;
      WAIT:
        if (sqrt_rdy || tmo)
          nstate = DONE;
      DONE:
        if (io.out_ready)
          nstate = IDLE;
      default:
        nstate = IDLE;
    endcase
  end

  // sqrt_start is a bare flop: it feeds the sqrt stage async reset
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      ax         <= '0;
      ay         <= '0;
      tcnt       <= '0;
      sqrt_x     <= '0;
      sqrt_start <= 1'b0;
      out_valid  <= 1'b0;
      out_err    <= 1'b0;
      out_mag    <= '0;
      out_mag2   <= '0;
    end else begin
      state <= nstate;
      unique case (state)
        IDLE:
          if (io.in_valid) begin
            ax <= abs16(io.in_x);
            ay <= abs16(io.in_y);
          end
        SQX: ;
        SQY:
          if (sq_done) begin
            sqrt_x     <= sq_sum;
            out_mag2   <= sq_sum;
            sqrt_start <= 1'b1;
          end
        START: begin
          sqrt_start <= 1'b0;
          tcnt       <= '0;
        end
        WAIT:
          if (sqrt_rdy) begin
            out_mag   <= sqrt_y;
            out_err   <= 1'b0;
            out_valid <= 1'b1;
          end else if (tmo) begin
            out_mag   <= '0;
            out_err   <= 1'b1;
            out_valid <= 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        DONE:
          if (io.out_ready)
            out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_mag_sqrt_feeder.sv
// Scoreboard bench for vec_mag_sqrt_feeder with a behavioural
// sqrt stage; directed boundary cases plus randomized vectors.
module tb_vec_mag_sqrt_feeder;
  import vec_mag_pkg::*;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [31:0] sqrt_x;
  logic        sqrt_start;
  logic        sqrt_rdy;
  logic [15:0] sqrt_y;

  always #5 CLK = ~CLK;

  vec_mag_sqrt_feeder_if bus();

  vec_mag_sqrt_feeder #(
    .W            (16),
    .SQRT_TIMEOUT (64)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .io         (bus),
    .sqrt_x     (sqrt_x),
    .sqrt_start (sqrt_start),
    .sqrt_rdy   (sqrt_rdy),
    .sqrt_y     (sqrt_y)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic int isqrt(longint v);
    longint lo = 0;
    longint hi = 65536;
    longint mid;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= v) lo = mid;
      else hi = mid;
    end
    return int'(lo);
  endfunction

  // sqrt stage model: held in reset by sqrt_start, ready 16
  // cycles after release; result valid only on that first cycle
  bit tie0 = 1'b0;
  int sc   = 1000;

  always @(posedge CLK or posedge sqrt_start)
    if (sqrt_start) sc <= 0;
    else if (sc < 1000) sc <= sc + 1;

  assign sqrt_rdy = !tie0 && (sc >= 16);
  assign sqrt_y   = (sc == 16) ? 16'(isqrt(longint'(sqrt_x)))
                               : 16'(sc * 37 + 1);

  typedef struct {
    longint mag2;
    int     mag;
    bit     err;
    int     lat;
    int     acc;
  } exp_t;

  exp_t q[$];

  task automatic check(string nm, longint act, longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // monitor: drives out_ready, checks against the scoreboard
  bit     hold_ready  = 1'b0;
  bit     rnd_bp      = 1'b0;
  bit     was_v       = 1'b0;
  bit     expect_idle = 1'b0;
  bit     r;
  int     last_hs     = -1;
  int     st_w        = 0;
  longint s_m2;
  int     s_mag;
  bit     s_err;
  exp_t   e;

  always @(negedge CLK) begin
    if (!RST_N) begin
      was_v         = 1'b0;
      expect_idle   = 1'b0;
      st_w          = 0;
      bus.out_ready = 1'b0;
    end else begin
      if (sqrt_start) st_w++;
      else if (st_w != 0) begin
        check("start_width", st_w, 1);
        st_w = 0;
      end
      if (expect_idle) begin
        check("idle_after_hs", bus.in_ready, 1);
        expect_idle = 1'b0;
      end
      if (hold_ready) r = 1'b0;
      else if (rnd_bp) r = 1'($urandom_range(0, 1));
      else r = 1'b1;
      bus.out_ready = r;
      if (bus.out_valid) begin
        check("busy_in_ready", bus.in_ready, 0);
        if (!was_v) begin
          s_m2  = bus.out_mag2;
          s_mag = bus.out_mag;
          s_err = bus.out_err;
          if (q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_out: got valid expected none");
          end else begin
            check("latency", cyc - q[0].acc, q[0].lat);
          end
        end else begin
          check("hold_mag2", bus.out_mag2, s_m2);
          check("hold_mag", bus.out_mag, s_mag);
          check("hold_err", bus.out_err, s_err);
        end
        if (r) begin
          if (q.size() != 0) begin
            e = q.pop_front();
            check("mag2", bus.out_mag2, e.mag2);
            check("mag", bus.out_mag, e.mag);
            check("err", bus.out_err, e.err);
          end
          last_hs     = cyc + 1;
          was_v       = 1'b0;
          expect_idle = 1'b1;
        end else begin
          was_v = 1'b1;
        end
      end
    end
  end

  task automatic send(input int x, input int y,
                      input longint m2, input int mag,
                      input bit err, input int lat,
                      output int acc);
    bit ok = 1'b0;
    bus.in_x     = 16'(x);
    bus.in_y     = 16'(y);
    bus.in_valid = 1'b1;
    for (int k = 0; k < 400; k++) begin
      @(negedge CLK);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge CLK);
    #1 acc = cyc;
    #1 bus.in_valid = 1'b0;
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept: in_ready got 0 expected 1");
    end else begin
      q.push_back('{mag2: m2, mag: mag, err: err,
                    lat: lat, acc: acc});
    end
  endtask

  task automatic wait_drain(input int max);
    for (int k = 0; k < max; k++) begin
      @(posedge CLK);
      #2;
      if (q.size() == 0 && !bus.out_valid) break;
    end
    check("drain", q.size(), 0);
  endtask

  task automatic chk_reset();
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_mag", bus.out_mag, 0);
    check("rst_out_mag2", bus.out_mag2, 0);
    check("rst_out_err", bus.out_err, 0);
    check("rst_sqrt_x", sqrt_x, 0);
    check("rst_sqrt_start", sqrt_start, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int     a;
    int     b;
    int     x;
    int     y;
    longint m2;
    bus.in_valid = 1'b0;
    bus.in_x     = '0;
    bus.in_y     = '0;
    RST_N        = 1'b0;
    repeat (3) @(posedge CLK);
    #2;
    chk_reset();
    RST_N = 1'b1;
    @(posedge CLK);
    #2;

    send(3, 4, 25, 5, 0, 50, a);
    wait_drain(200);
    send(-32768, -32768, 64'd2147483648, 46340, 0, 50, a);
    wait_drain(200);

    // consumer stalls; a busy-time request must not be latched
    hold_ready = 1'b1;
    send(1000, -1000, 2000000, 1414, 0, 50, a);
    for (int k = 0; k < 200; k++) begin
      @(posedge CLK);
      #2;
      if (bus.out_valid) break;
    end
    bus.in_x     = 16'sd7;
    bus.in_y     = 16'sd7;
    bus.in_valid = 1'b1;
    repeat (20) @(posedge CLK);
    #2;
    check("stall_in_ready", bus.in_ready, 0);
    bus.in_valid = 1'b0;
    hold_ready   = 1'b0;
    wait_drain(200);

    send(0, 0, 0, 0, 0, 50, a);
    send(5, 12, 169, 13, 0, 50, b);
    check("b2b_accept", b, last_hs + 1);
    wait_drain(200);

    tie0 = 1'b1;
    send(3, 4, 25, 0, 1, 97, a);
    wait_drain(300);
    tie0 = 1'b0;

    // reset lands while the Y square is in progress
    send(9, 9, 162, 12, 0, 50, a);
    repeat (20) @(posedge CLK);
    #3 RST_N = 1'b0;
    #1 chk_reset();
    q.delete();
    @(posedge CLK);
    #2 RST_N = 1'b1;
    send(6, 8, 100, 10, 0, 50, a);
    wait_drain(200);

    rnd_bp = 1'b1;
    for (int i = 0; i < 10; i++) begin
      x  = int'($urandom_range(0, 65535)) - 32768;
      y  = int'($urandom_range(0, 65535)) - 32768;
      m2 = longint'(x) * x + longint'(y) * y;
      send(x, y, m2, isqrt(m2), 0, 50, a);
      repeat ($urandom_range(0, 3)) @(posedge CLK);
    end
    wait_drain(2000);
    rnd_bp = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
